alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: XLEN, 32, datapath width in bits (legal values 32 or 64).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 ALUOp  input  2  00 add, 01 sub, 10/11 decode from funct fields.
REQ-007 opb5  input  1  opcode bit 5 (1 = R-type).
REQ-008 funct3  input  3  instruction funct3.
REQ-009 funct7b5  input  1  funct7 bit 5 (sub/sra select).
REQ-010 funct7b0  input  1  funct7 bit 0 (M-extension select).
REQ-011 a, b  input  XLEN each  source operands.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 result  output  XLEN  operation result.
REQ-015 zero  output  1  result == 0.

Function
REQ-016 Request accepted when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-017 Decode, ALUOp 00: add; 01: sub; otherwise funct3 000 add/sub (sub if funct7b5&&opb5), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra (sra if funct7b5), 110 or, 111 and.
REQ-018 M-extension, ALUOp!=00/01 && opb5 && funct7b0: funct3 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu; overrides REQ-017.
REQ-019 Shift amount = b[log2(XLEN)-1:0]; upper bits ignored.
REQ-020 Add/sub/mul wrap modulo 2^XLEN; mulh* returns upper XLEN bits of the 2*XLEN product with RISC-V signedness.
REQ-021 Non-divide ops: latency 1; result registered, out_valid asserted the cycle after acceptance.
REQ-022 Divide/remainder ops: FSM IDLE -> DIV on acceptance; exactly XLEN iteration cycles in DIV; result loaded and out_valid asserted on the DIV -> IDLE transition; total latency XLEN+1.
REQ-023 Divide by zero: quotient all ones (div, divu), remainder = dividend (rem, remu); same latency as a normal divide.
REQ-024 Signed overflow (a = most-negative, b = -1): div returns a, rem returns 0.
REQ-025 Operands latched at acceptance; later changes on a, b and the funct fields have no effect on an in-flight op.
REQ-026 result and out_valid hold stable while out_valid && !out_ready.
REQ-027 Back-to-back: out_ready=1 with in_valid=1 every cycle sustains one non-divide op per cycle.
REQ-028 zero is combinational from the result register and valid only when out_valid=1.

Reset
REQ-029 On reset: state = IDLE, out_valid = 0, result = 0, divider iteration count = 0.
REQ-030 Reset during DIV aborts the divide; no result is produced.
REQ-031 in_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-032 Package alu_pkg holds alu_op_t (5-bit enum of all 18 operations) and the FSM state type; XLEN stays a module parameter.
REQ-033 Decode is a combinational function in alu_pkg mapping {ALUOp, opb5, funct3, funct7b5, funct7b0} to alu_op_t.
REQ-034 Sub-module div_iter (XLEN-parameterised, restoring, one quotient bit per cycle, start/done) is instantiated once.

Verification
REQ-035 ALUOp=10, opb5=1, funct3=000, funct7b5=1, a=5, b=7 -> result 0xFFFFFFFE one cycle after acceptance, zero=0.
REQ-036 sra, a=0x80000000, b=0x24 -> result 0xF8000000 (shift 4).
REQ-037 div, a=0x80000000, b=0xFFFFFFFF -> result 0x80000000 after 33 cycles; rem on the same operands -> 0.
REQ-038 divu, a=100, b=0 -> result 0xFFFFFFFF; remu, a=100, b=0 -> 100; in_ready=0 throughout DIV.
REQ-039 out_ready held 0 for 3 cycles after an add -> result stable, in_ready=0; after release, a 10-op back-to-back stream completes at 1 op/cycle.
REQ-040 reset asserted at DIV cycle 10 -> out_valid=0, in_ready=1 after reset deasserts, next add correct; repeat all scenarios with XLEN=64.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and decode helpers for the ALU execute block.
package alu_pkg;

    // Every operation the execute stage can perform.
    typedef enum logic [4:0] {
        OpAdd,
        OpSub,
        OpSll,
        OpSlt,
        OpSltu,
        OpXor,
        OpSrl,
        OpSra,
        OpOr,
        OpAnd,
        OpMul,
        OpMulh,
        OpMulhsu,
        OpMulhu,
        OpDiv,
        OpDivu,
        OpRem,
        OpRemu
    } alu_op_t;

    // Top-level control state: idle or waiting on the iterative divider.
    typedef enum logic [0:0] {
        StIdle,
        StDiv
    } alu_state_t;

    // Maps the main-decoder ALUOp and instruction fields onto an operation.
    function automatic alu_op_t alu_decode(
        input logic [1:0] alu_op,
        input logic       opb5,
        input logic [2:0] funct3,
        input logic       funct7b5,
        input logic       funct7b0
    );
        alu_op_t op;
        op = OpAdd;
        case (alu_op)
            2'b00: op = OpAdd;
            2'b01: op = OpSub;
            default: begin
                // M-extension only exists for R-type encodings
                if (opb5 && funct7b0) begin
                    case (funct3)
                        3'b000:  op = OpMul;
                        3'b001:  op = OpMulh;
                        3'b010:  op = OpMulhsu;
                        3'b011:  op = OpMulhu;
                        3'b100:  op = OpDiv;
                        3'b101:  op = OpDivu;
                        3'b110:  op = OpRem;
                        default: op = OpRemu;
                    endcase
                end else begin
                    case (funct3)
                        3'b000:  op = (funct7b5 && opb5) ? OpSub : OpAdd;
                        3'b001:  op = OpSll;
                        3'b010:  op = OpSlt;
                        3'b011:  op = OpSltu;
                        3'b100:  op = OpXor;
                        3'b101:  op = funct7b5 ? OpSra : OpSrl;
                        3'b110:  op = OpOr;
                        default: op = OpAnd;
                    endcase
                end
            end
        endcase
        return op;
    endfunction

    // True for the multi-cycle divide/remainder group.
    function automatic logic is_div_op(input alu_op_t op);
        return (op == OpDiv) || (op == OpDivu) || (op == OpRem) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle, XLEN iterations.
// Quotient/remainder outputs present the value of the final step while done is
// high, so the caller can capture them on the same edge as the last iteration.
module div_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvs;
    logic [CntW-1:0] r_cnt;

    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_rem_next;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    always_comb begin
        w_shift    = {r_rem, r_quo[XLEN-1]};
        w_diff     = w_shift - {1'b0, r_dvs};
        w_qbit     = ~w_diff[XLEN];
        w_quo_next = {r_quo[XLEN-2:0], w_qbit};
        w_rem_next = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    end

    assign o_done      = (r_cnt == CntW'(1));
    assign o_quotient  = w_quo_next;
    assign o_remainder = w_rem_next;

    // Load operands on start, then iterate until the count runs out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
            r_cnt <= CntW'(XLEN);
        end else if (r_cnt != '0) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Integer execute unit: single-cycle RV32/64 IM ALU ops plus an iterative
// divider, with valid/ready handshakes on both sides.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic            opb5,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int unsigned ShW = $clog2(XLEN);

    alu_state_t      r_state;
    alu_state_t      w_state_next;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    alu_op_t         r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;

    alu_op_t           w_op;
    logic              w_accept;
    logic              w_is_div;
    logic              w_start;
    logic [ShW-1:0]    w_shamt;
    logic [2*XLEN-1:0] w_ma;
    logic [2*XLEN-1:0] w_mb;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_alu_res;

    logic            w_div_signed;
    logic [XLEN-1:0] w_dvd;
    logic [XLEN-1:0] w_dvs;
    logic            w_div_done;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic            w_r_signed;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_div_res;

    assign w_op     = alu_decode(ALUOp, opb5, funct3, funct7b5, funct7b0);
    assign w_is_div = is_div_op(w_op);
    assign in_ready = (r_state == StIdle) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_start  = w_accept && w_is_div;
    assign w_shamt  = b[ShW-1:0];

    // Single-cycle datapath; one shared multiplier with per-op operand extension.
    always_comb begin
        w_ma = (w_op == OpMulh || w_op == OpMulhsu) ? {{XLEN{a[XLEN-1]}}, a}
                                                   : {{XLEN{1'b0}}, a};
        w_mb = (w_op == OpMulh) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        w_prod = w_ma * w_mb;
        w_alu_res = '0;
        case (w_op)
            OpAdd:    w_alu_res = a + b;
            OpSub:    w_alu_res = a - b;
            OpSll:    w_alu_res = a << w_shamt;
            OpSlt:    w_alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OpSltu:   w_alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            OpXor:    w_alu_res = a ^ b;
            OpSrl:    w_alu_res = a >> w_shamt;
            OpSra:    w_alu_res = $unsigned($signed(a) >>> w_shamt);
            OpOr:     w_alu_res = a | b;
            OpAnd:    w_alu_res = a & b;
            OpMul:    w_alu_res = w_prod[XLEN-1:0];
            OpMulh,
            OpMulhsu,
            OpMulhu:  w_alu_res = w_prod[2*XLEN-1:XLEN];
            default:  w_alu_res = '0;
        endcase
    end

    // Divider works on magnitudes; signs are reapplied from the latched operands.
    always_comb begin
        w_div_signed = (w_op == OpDiv) || (w_op == OpRem);
        w_dvd = (w_div_signed && a[XLEN-1]) ? -a : a;
        w_dvs = (w_div_signed && b[XLEN-1]) ? -b : b;
    end

    div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_start),
        .i_dividend  (w_dvd),
        .i_divisor   (w_dvs),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Sign fix-up and divide-by-zero override; overflow falls out of the magnitudes.
    always_comb begin
        w_r_signed = (r_op == OpDiv) || (r_op == OpRem);
        if (r_b == '0) begin
            w_quo_fix = '1;
            w_rem_fix = r_a;
        end else begin
            w_quo_fix = (w_r_signed && (r_a[XLEN-1] ^ r_b[XLEN-1])) ? -w_quo : w_quo;
            w_rem_fix = (w_r_signed && r_a[XLEN-1]) ? -w_rem : w_rem;
        end
        w_div_res = (r_op == OpDiv || r_op == OpDivu) ? w_quo_fix : w_rem_fix;
    end

    // Next-state logic: enter DIV on a divide accept, leave when the divider finishes.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_start) w_state_next = StDiv;
            StDiv:   if (w_div_done) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Result/valid registers and operand latches for in-flight divides.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_op        <= OpAdd;
            r_a         <= '0;
            r_b         <= '0;
        end else if (w_accept) begin
            r_op <= w_op;
            r_a  <= a;
            r_b  <= b;
            if (w_is_div) begin
                r_out_valid <= 1'b0;
            end else begin
                r_result    <= w_alu_res;
                r_out_valid <= 1'b1;
            end
        end else if (r_state == StDiv && w_div_done) begin
            r_result    <= w_div_res;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = (r_result == '0);

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: runs every scenario on an XLEN=32 and an
// XLEN=64 instance in turn.
module tb_alu_exec;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        sel64;
    logic [1:0]  alu_op;
    logic        opb5;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        funct7b0;
    logic [63:0] a;
    logic [63:0] b;

    logic        iv32, iv64;
    logic        rdy32, rdy64, ov32, ov64, z32, z64;
    logic [31:0] res32;
    logic [63:0] res64;

    logic        t_rdy, t_ov, t_zero;
    logic [63:0] t_res;

    assign iv32   = in_valid && !sel64;
    assign iv64   = in_valid && sel64;
    assign t_rdy  = sel64 ? rdy64 : rdy32;
    assign t_ov   = sel64 ? ov64 : ov32;
    assign t_zero = sel64 ? z64 : z32;
    assign t_res  = sel64 ? res64 : {32'h0, res32};

    alu_exec #(.XLEN(32)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(rdy32), .ALUOp(alu_op),
        .opb5(opb5), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
        .a(a[31:0]), .b(b[31:0]), .out_valid(ov32), .out_ready(out_ready),
        .result(res32), .zero(z32)
    );

    alu_exec #(.XLEN(64)) u_dut64 (
        .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(rdy64), .ALUOp(alu_op),
        .opb5(opb5), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
        .a(a), .b(b), .out_valid(ov64), .out_ready(out_ready),
        .result(res64), .zero(z64)
    );

    typedef struct {
        string       name;
        logic [1:0]  aluop;
        logic        opb5;
        logic [2:0]  f3;
        logic        f7b5;
        logic        f7b0;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp32;
        logic [63:0] exp64;
        logic        dv;
    } vec_t;

    localparam logic [63:0] MONE = 64'hFFFF_FFFF_FFFF_FFFF;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (xlen64=%0b): got %h expected %h", name, sel64, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [1:0] op, input logic o5,
                                input logic [2:0] f3, input logic f7b5, input logic f7b0,
                                input logic [63:0] av, input logic [63:0] bv,
                                input logic [63:0] e32, input logic [63:0] e64,
                                input logic dv);
        vec_t v;
        v.name = n; v.aluop = op; v.opb5 = o5; v.f3 = f3; v.f7b5 = f7b5; v.f7b0 = f7b0;
        v.a = av; v.b = bv; v.exp32 = e32; v.exp64 = e64; v.dv = dv;
        return v;
    endfunction

    // Issue one op, scramble the inputs after acceptance, then check latency and result.
    task automatic run_op(input vec_t v, input logic [63:0] exp);
        int          lat;
        int          w;
        logic        busy_ok;
        logic [63:0] mask;
        mask = sel64 ? MONE : 64'hFFFF_FFFF;
        w = 0;
        @(negedge clk);
        while (!t_rdy && w < 300) begin
            @(negedge clk);
            w++;
        end
        check({v.name, " in_ready"}, {63'h0, t_rdy}, 64'h1);
        alu_op = v.aluop; opb5 = v.opb5; funct3 = v.f3; funct7b5 = v.f7b5;
        funct7b0 = v.f7b0; a = v.a; b = v.b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~v.a; b = ~v.b; funct3 = ~v.f3; funct7b0 = ~v.f7b0; funct7b5 = ~v.f7b5;
        alu_op = ~v.aluop;
        lat = 1;
        busy_ok = 1'b1;
        while (!t_ov && lat < 300) begin
            if (t_rdy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({v.name, " latency"}, 64'(lat), v.dv ? (sel64 ? 64'd65 : 64'd33) : 64'd1);
        if (v.dv) check({v.name, " busy"}, {63'h0, busy_ok}, 64'h1);
        check({v.name, " result"}, t_res, exp & mask);
        check({v.name, " zero"}, {63'h0, t_zero}, {63'h0, (exp & mask) == 64'h0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        v;
        logic [63:0] minv;
        logic        quiet;

        vecs.push_back(mk("sub_r", 2, 1, 0, 1, 0, 5, 7, 64'hFFFF_FFFE, MONE - 1, 0));
        vecs.push_back(mk("add_wrap", 0, 0, 0, 0, 0, MONE, 1, 0, 0, 0));
        vecs.push_back(mk("aluop_sub", 1, 0, 0, 0, 0, 10, 3, 7, 7, 0));
        vecs.push_back(mk("addi", 2, 0, 0, 1, 0, 5, 7, 12, 12, 0));
        vecs.push_back(mk("add_ovr", 0, 1, 0, 0, 1, 3, 4, 7, 7, 0));
        vecs.push_back(mk("sll", 2, 1, 1, 0, 0, 1, 64'h25, 64'h20, 64'h20_0000_0000, 0));
        vecs.push_back(mk("sra", 2, 1, 5, 1, 0, 64'h8000_0000_8000_0000, 64'h24,
                          64'hF800_0000, 64'hFFFF_FFFF_F800_0000, 0));
        vecs.push_back(mk("srl", 2, 1, 5, 0, 0, 64'h8000_0000_8000_0000, 64'h24,
                          64'h0800_0000, 64'h0800_0000, 0));
        vecs.push_back(mk("slt", 2, 1, 2, 0, 0, MONE, 1, 1, 1, 0));
        vecs.push_back(mk("sltu", 2, 1, 3, 0, 0, MONE, 1, 0, 0, 0));
        vecs.push_back(mk("xor", 2, 1, 4, 0, 0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                          64'h0FF0_0FF0, 64'h0FF0_0FF0_0FF0_0FF0, 0));
        vecs.push_back(mk("or", 2, 1, 6, 0, 0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                          64'hFFF0_FFF0, 64'hFFF0_FFF0_FFF0_FFF0, 0));
        vecs.push_back(mk("and", 2, 1, 7, 0, 0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                          64'hF000_F000, 64'hF000_F000_F000_F000, 0));
        vecs.push_back(mk("mul", 2, 1, 0, 0, 1, MONE - 2, 7, 64'hFFFF_FFEB, MONE - 20, 0));
        vecs.push_back(mk("mulh", 2, 1, 1, 0, 1, MONE - 1, MONE, 0, 0, 0));
        vecs.push_back(mk("mulhsu", 2, 1, 2, 0, 1, MONE - 1, MONE, 64'hFFFF_FFFE, MONE - 1, 0));
        vecs.push_back(mk("mulhu", 2, 1, 3, 0, 1, MONE - 1, MONE, 64'hFFFF_FFFD, MONE - 2, 0));
        vecs.push_back(mk("div", 2, 1, 4, 0, 1, MONE - 6, 2, 64'hFFFF_FFFD, MONE - 2, 1));
        vecs.push_back(mk("rem", 2, 1, 6, 0, 1, MONE - 6, 2, 64'hFFFF_FFFF, MONE, 1));
        vecs.push_back(mk("divu", 2, 1, 5, 0, 1, 100, 7, 14, 14, 1));
        vecs.push_back(mk("remu", 2, 1, 7, 0, 1, 100, 7, 2, 2, 1));
        vecs.push_back(mk("divu_z", 2, 1, 5, 0, 1, 100, 0, 64'hFFFF_FFFF, MONE, 1));
        vecs.push_back(mk("remu_z", 2, 1, 7, 0, 1, 100, 0, 100, 100, 1));
        vecs.push_back(mk("div_z", 2, 1, 4, 0, 1, MONE - 4, 0, 64'hFFFF_FFFF, MONE, 1));
        vecs.push_back(mk("rem_z", 2, 1, 6, 0, 1, MONE - 4, 0, 64'hFFFF_FFFB, MONE - 4, 1));
        vecs.push_back(mk("divu_big", 2, 1, 5, 0, 1, MONE, 64'h10,
                          64'h0FFF_FFFF, 64'h0FFF_FFFF_FFFF_FFFF, 1));

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel64 = 1'b0;
        alu_op = 0; opb5 = 0; funct3 = 0; funct7b5 = 0; funct7b0 = 0; a = 0; b = 0;

        for (int pass = 0; pass < 2; pass++) begin
            sel64 = (pass == 1);
            reset = 1'b1;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            check("reset out_valid", {63'h0, t_ov}, 64'h0);
            check("reset in_ready", {63'h0, t_rdy}, 64'h1);
            check("reset result", t_res, 64'h0);

            foreach (vecs[i]) run_op(vecs[i], sel64 ? vecs[i].exp64 : vecs[i].exp32);

            // Signed overflow: most-negative / -1.
            minv = sel64 ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
            v = mk("div_ovf", 2, 1, 4, 0, 1, minv, MONE, minv, minv, 1);
            run_op(v, minv);
            v = mk("rem_ovf", 2, 1, 6, 0, 1, minv, MONE, 0, 0, 1);
            run_op(v, 64'h0);

            // Backpressure on an add, then a sustained stream.
            @(negedge clk);
            out_ready = 1'b0;
            alu_op = 0; a = 2; b = 3; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; a = 64'hDEAD;
            for (int i = 0; i < 3; i++) begin
                check("bp out_valid", {63'h0, t_ov}, 64'h1);
                check("bp result", t_res, 64'd5);
                check("bp in_ready", {63'h0, t_rdy}, 64'h0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            for (int k = 0; k < 10; k++) begin
                alu_op = 0; a = 64'(k); b = 100; in_valid = 1'b1;
                @(negedge clk);
                check("stream out_valid", {63'h0, t_ov}, 64'h1);
                check("stream result", t_res, 64'(k + 100));
            end
            in_valid = 1'b0;

            // Reset in the middle of a divide aborts it.
            @(negedge clk);
            alu_op = 2; opb5 = 1; funct3 = 5; funct7b5 = 0; funct7b0 = 1;
            a = 100; b = 7; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (9) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("abort out_valid", {63'h0, t_ov}, 64'h0);
            check("abort in_ready", {63'h0, t_rdy}, 64'h1);
            quiet = 1'b1;
            repeat (sel64 ? 70 : 38) begin
                @(negedge clk);
                if (t_ov) quiet = 1'b0;
            end
            check("abort no result", {63'h0, quiet}, 64'h1);
            v = mk("add_after_abort", 0, 0, 0, 0, 0, 20, 22, 42, 42, 0);
            run_op(v, 64'd42);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
